// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable 50% duty-cycle clock divider.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int unsigned DIV_MIN = 32'd2;

  // Divisors below DIV_MIN cannot produce a 50% output, so they saturate.
  function automatic int unsigned clamp_div(input int unsigned v);
    if (v < DIV_MIN) begin
      return DIV_MIN;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/clk_div_phase_gen.sv
// Negedge retimer and odd/even output mux; the only negedge logic in the divider.
module clk_div_phase_gen
  import clk_div_pkg::*;
(
  input  logic iclk,
  input  logic rstn,
  input  logic p_phase_i,
  input  logic odd_i,
  output logic oclk_o
);

  logic n_phase_q;

  // Half-cycle delayed copy of the posedge phase, used to stretch odd divisors.
  always_ff @(negedge iclk or negedge rstn) begin
    if (!rstn) begin
      n_phase_q <= 1'b0;
    end else begin
      n_phase_q <= p_phase_i;
    end
  end

  assign oclk_o = odd_i ? (p_phase_i | n_phase_q) : p_phase_i;

endmodule

// File: rtl/clk_div_n.sv
// Programmable integer clock divider: FSM, period counter and shadowed divisor.
module clk_div_n
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DEFAULT_DIV = 3
) (
  input  logic             iclk,
  input  logic             rstn,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_val_i,
  input  logic             div_load_i,
  output logic             div_ack_o,
  output logic             oclk_o,
  output logic             tick_o,
  output logic             busy_o
);

  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_act_q, div_act_d;
  logic [DIV_W-1:0] div_shd_q, div_shd_d;
  logic             pend_q, pend_d;
  logic             p_phase_q, p_phase_d;
  logic             div_ack_q, div_ack_d;
  logic             tick_q, tick_d;
  logic             busy_q, busy_d;
  logic             running_s;
  logic             boundary_s;

  assign running_s  = (state_q != IDLE);
  assign boundary_s = running_s && (cnt_q == (div_act_q - ONE));

  // State register and all posedge datapath registers.
  always_ff @(posedge iclk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_act_q <= DEF_DIV;
      div_shd_q <= DEF_DIV;
      pend_q    <= 1'b0;
      p_phase_q <= 1'b0;
      div_ack_q <= 1'b0;
      tick_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_act_q <= div_act_d;
      div_shd_q <= div_shd_d;
      pend_q    <= pend_d;
      p_phase_q <= p_phase_d;
      div_ack_q <= div_ack_d;
      tick_q    <= tick_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state, counter, divisor hand-over and output decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_act_d = div_act_q;
    div_shd_d = div_shd_q;
    pend_d    = pend_q;

    case (state_q)
      IDLE: begin
        if (en_i) state_d = RUN;
        else      state_d = IDLE;
      end
      RUN, DRAIN: begin
        if (en_i)            state_d = RUN;
        else if (boundary_s) state_d = IDLE;
        else                 state_d = DRAIN;
      end
      default: state_d = IDLE;
    endcase

    // A fresh start and every boundary restart the period at zero.
    if ((state_d == IDLE) || !running_s || boundary_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + ONE;
    end

    // The boundary consumes the old shadow before a same-edge load overwrites it.
    if (boundary_s && pend_q) begin
      div_act_d = div_shd_q;
      pend_d    = 1'b0;
    end else begin
      div_act_d = div_act_q;
    end
    if (div_load_i) begin
      div_shd_d = DIV_W'(clamp_div(32'(div_val_i)));
      pend_d    = 1'b1;
    end else begin
      div_shd_d = div_shd_q;
    end

    p_phase_d = (state_d != IDLE) && (cnt_d < (div_act_q >> 1));
    tick_d    = (state_d != IDLE) && (cnt_d == '0);
    busy_d    = (state_d != IDLE);
    div_ack_d = boundary_s && pend_q;
  end

  clk_div_phase_gen u_phase_gen (
    .iclk      (iclk),
    .rstn      (rstn),
    .p_phase_i (p_phase_q),
    .odd_i     (div_act_q[0]),
    .oclk_o    (oclk_o)
  );

  assign div_ack_o = div_ack_q;
  assign tick_o    = tick_q;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_clk_div_n.sv
// Self-checking bench for clk_div_n: directed vector table, corner sequences, random run vs model.
module tb_clk_div_n;

  logic       iclk = 1'b0;
  logic       rstn = 1'b0;
  logic       en_i = 1'b0;
  logic [7:0] div_val_i = 8'd0;
  logic       div_load_i = 1'b0;
  logic       div_ack_o, oclk_o, tick_o, busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: period length, position within period, shadow, pending flag.
  bit m_run;
  int m_idx, m_n, m_shd;
  bit m_pend;
  bit e_ack;

  logic s_o1, s_o2, s_tick, s_busy, s_ack;

  typedef struct {
    logic       en;
    logic       load;
    logic [7:0] val;
    logic       busy;
    logic       tick;
    logic       ack;
    logic       o1;
    logic       o2;
  } vec_t;

  vec_t tbl[16];

  clk_div_n dut (
    .iclk       (iclk),
    .rstn       (rstn),
    .en_i       (en_i),
    .div_val_i  (div_val_i),
    .div_load_i (div_load_i),
    .div_ack_o  (div_ack_o),
    .oclk_o     (oclk_o),
    .tick_o     (tick_o),
    .busy_o     (busy_o)
  );

  always #5 iclk = ~iclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_idx = 0; m_n = 3; m_shd = 3; m_pend = 1'b0; e_ack = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0; en_i = 1'b0; div_load_i = 1'b0; div_val_i = 8'd0;
    repeat (2) @(negedge iclk);
    model_reset();
    rstn = 1'b1;
    #1;
  endtask

  // One source-clock cycle: drive, update the model at posedge, check both half cycles.
  task automatic step(input logic e, input logic l, input logic [7:0] v);
    bit bnd, nx_run;
    en_i = e; div_load_i = l; div_val_i = v;
    @(posedge iclk);
    bnd   = m_run && (m_idx == m_n - 1);
    e_ack = bnd && m_pend;
    if (e_ack) begin
      m_n = m_shd; m_pend = 1'b0;
    end
    nx_run = e || (m_run && !bnd);
    if (nx_run && m_run && !bnd) m_idx = m_idx + 1;
    else                         m_idx = 0;
    m_run = nx_run;
    if (l) begin
      m_shd = (int'(v) < 2) ? 2 : int'(v);
      m_pend = 1'b1;
    end
    #1;
    s_o1 = oclk_o; s_tick = tick_o; s_busy = busy_o; s_ack = div_ack_o;
    // High time is N half-cycles of each 2N-half-cycle period, odd or even N.
    chk("oclk_first_half", oclk_o, {31'd0, m_run && (2 * m_idx < m_n)});
    chk("tick", tick_o, {31'd0, m_run && (m_idx == 0)});
    chk("busy", busy_o, {31'd0, m_run});
    chk("div_ack", div_ack_o, {31'd0, e_ack});
    @(negedge iclk);
    #1;
    s_o2 = oclk_o;
    chk("oclk_second_half", oclk_o, {31'd0, m_run && (2 * m_idx + 1 < m_n)});
  endtask

  initial begin
    int acks;
    //         en    load  val     busy  tick  ack   o1    o2
    tbl[0]  = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 8'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    model_reset();
    #2;
    chk("reset_oclk", oclk_o, 32'd0);
    chk("reset_busy", busy_o, 32'd0);
    chk("reset_tick", tick_o, 32'd0);
    chk("reset_ack", div_ack_o, 32'd0);
    do_reset();

    // Directed table: N=3 start, load N=4 mid-period, stop through DRAIN.
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].en, tbl[i].load, tbl[i].val);
      chk($sformatf("tbl%0d_busy", i), s_busy, {31'd0, tbl[i].busy});
      chk($sformatf("tbl%0d_tick", i), s_tick, {31'd0, tbl[i].tick});
      chk($sformatf("tbl%0d_ack", i),  s_ack,  {31'd0, tbl[i].ack});
      chk($sformatf("tbl%0d_o1", i),   s_o1,   {31'd0, tbl[i].o1});
      chk($sformatf("tbl%0d_o2", i),   s_o2,   {31'd0, tbl[i].o2});
    end

    // Two loads before one boundary: single ack, last value wins.
    step(1'b1, 1'b1, 8'd7);
    step(1'b1, 1'b1, 8'd5);
    acks = 0;
    for (int k = 0; k < 24; k++) begin
      step(1'b1, 1'b0, 8'd0);
      if (s_ack) acks++;
    end
    chk("double_load_acks", acks, 32'd1);
    chk("double_load_div", m_n, 32'd5);

    // Clamping of 0 and 1.
    step(1'b1, 1'b1, 8'd0);
    for (int k = 0; k < 12; k++) step(1'b1, 1'b0, 8'd0);
    step(1'b1, 1'b1, 8'd1);
    for (int k = 0; k < 12; k++) step(1'b1, 1'b0, 8'd0);

    // N=6: drop en at cnt=1, drain to idle.
    step(1'b1, 1'b1, 8'd6);
    for (int k = 0; k < 30 && !(m_n == 6 && m_idx == 1); k++) step(1'b1, 1'b0, 8'd0);
    chk("wait_n6_idx1", {31'd0, (m_n == 6 && m_idx == 1)}, 32'd1);
    for (int k = 0; k < 12 && m_run; k++) step(1'b0, 1'b0, 8'd0);
    chk("drain_reached_idle", busy_o, 32'd0);
    step(1'b0, 1'b0, 8'd0);
    chk("idle_oclk_low", oclk_o, 32'd0);

    // Re-assert en during DRAIN: count continues without a gap.
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 8'd0);
    step(1'b0, 1'b0, 8'd0);
    for (int k = 0; k < 14; k++) step(1'b1, 1'b0, 8'd0);

    // Reset mid high phase after a non-default divisor has been applied.
    for (int k = 0; k < 20 && !(m_run && m_idx == 0); k++) step(1'b1, 1'b0, 8'd0);
    chk("pre_reset_oclk_high", oclk_o, 32'd1);
    rstn = 1'b0;
    #1;
    chk("async_reset_oclk", oclk_o, 32'd0);
    chk("async_reset_busy", busy_o, 32'd0);
    #2;
    rstn = 1'b1;
    model_reset();
    #1;
    step(1'b0, 1'b0, 8'd0);
    chk("post_reset_idle", busy_o, 32'd0);
    for (int k = 0; k < 9; k++) step(1'b1, 1'b0, 8'd0);

    // Randomized run against the model.
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      logic e, l;
      logic [7:0] v;
      e = ($urandom_range(0, 9) != 0);
      l = ($urandom_range(0, 19) == 0);
      v = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
      if (v > 8'd40) v = 8'd40;
      step(e, l, v);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
